// File: rtl/dcache_pkg.sv
// Shared geometry, address-field helpers and FSM state encoding for the
// direct-mapped data cache controller.
package dcache_pkg;

    localparam int NUM_LINES   = 32;
    localparam int LINE_BITS   = 256;
    localparam int TAG_BITS    = 22;
    localparam int ADDR_BITS   = 32;
    localparam int WORD_BITS   = 32;
    localparam int INDEX_BITS  = 5;
    localparam int WORD_SEL_BITS = 3;
    localparam int BYTE_OFF_BITS = 5;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MISS       = 3'd1,
        WRITEBACK  = 3'd2,
        READMISS   = 3'd3,
        READMISSOK = 3'd4
    } state_e;

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_BITS-1:0] addr);
        return addr[31:10];
    endfunction

    function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDR_BITS-1:0] addr);
        return addr[9:5];
    endfunction

    function automatic logic [WORD_SEL_BITS-1:0] addr_word(input logic [ADDR_BITS-1:0] addr);
        return addr[4:2];
    endfunction

    // Extract one 32-bit word from a line.
    function automatic logic [WORD_BITS-1:0] line_get_word(input logic [LINE_BITS-1:0] line,
                                                           input logic [WORD_SEL_BITS-1:0] sel);
        logic [7:0] base;
        base = {sel, 5'b00000};
        return line[base +: WORD_BITS];
    endfunction

    // Replace one 32-bit word inside a line.
    function automatic logic [LINE_BITS-1:0] line_put_word(input logic [LINE_BITS-1:0] line,
                                                           input logic [WORD_SEL_BITS-1:0] sel,
                                                           input logic [WORD_BITS-1:0] word);
        logic [LINE_BITS-1:0] res;
        logic [7:0]           base;
        res  = line;
        base = {sel, 5'b00000};
        res[base +: WORD_BITS] = word;
        return res;
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/data storage: 32 entries, asynchronous read, synchronous write.
// Reset clears only the valid and dirty bits; tags and data keep their contents.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    output logic                  rd_valid_o,
    output logic                  rd_dirty_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [LINE_BITS-1:0]  rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic                  wr_valid_i,
    input  logic                  wr_dirty_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [LINE_BITS-1:0]  wr_data_i
);

    logic [NUM_LINES-1:0] valid_r;
    logic [NUM_LINES-1:0] dirty_r;
    logic [TAG_BITS-1:0]  tag_r  [NUM_LINES];
    logic [LINE_BITS-1:0] data_r [NUM_LINES];

    assign rd_valid_o = valid_r[rd_index_i];
    assign rd_dirty_o = dirty_r[rd_index_i];
    assign rd_tag_o   = tag_r[rd_index_i];
    assign rd_data_o  = data_r[rd_index_i];

    // Status bits: cleared by reset, updated on every write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r <= {NUM_LINES{1'b0}};
            dirty_r <= {NUM_LINES{1'b0}};
        end else if (wr_en_i) begin
            valid_r[wr_index_i] <= wr_valid_i;
            dirty_r[wr_index_i] <= wr_dirty_i;
        end else begin
            valid_r <= valid_r;
            dirty_r <= dirty_r;
        end
    end

    // Tag and data arrays: plain storage, never reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_r[wr_index_i]  <= wr_tag_i;
            data_r[wr_index_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller sitting between the MEM
// pipeline stage and a line-wide memory with a single-cycle ack handshake.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_BITS-1:0] p1_addr_i,
    input  logic [WORD_BITS-1:0] p1_data_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [WORD_BITS-1:0] p1_data_o,
    output logic                 p1_stall_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    state_e                state_r;
    state_e                state_nxt_s;
    logic                  mem_enable_r;
    logic                  mem_write_r;
    logic [ADDR_BITS-1:0]  mem_addr_r;
    logic [LINE_BITS-1:0]  mem_data_r;
    logic [LINE_BITS-1:0]  refill_r;

    logic                  req_s;
    logic [TAG_BITS-1:0]   req_tag_s;
    logic [INDEX_BITS-1:0] req_index_s;
    logic [WORD_SEL_BITS-1:0] req_word_s;
    logic                  hit_s;

    logic                  rd_valid_s;
    logic                  rd_dirty_s;
    logic [TAG_BITS-1:0]   rd_tag_s;
    logic [LINE_BITS-1:0]  rd_data_s;

    logic                  wr_en_s;
    logic                  wr_valid_s;
    logic                  wr_dirty_s;
    logic [TAG_BITS-1:0]   wr_tag_s;
    logic [LINE_BITS-1:0]  wr_data_s;

    logic                  unused_s;

    // Byte-within-word bits play no part in a word-granular cache.
    assign unused_s = ^p1_addr_i[1:0];

    // A write wins when both strobes are high, so MemWrite alone selects the write path.
    assign req_s       = p1_MemRead_i | p1_MemWrite_i;
    assign req_tag_s   = addr_tag(p1_addr_i);
    assign req_index_s = addr_index(p1_addr_i);
    assign req_word_s  = addr_word(p1_addr_i);

    // The request inputs are frozen by the stalled pipeline, so the array is
    // addressed by them throughout a miss and reads back the victim line.
    dcache_sram u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_index_i (req_index_s),
        .rd_valid_o (rd_valid_s),
        .rd_dirty_o (rd_dirty_s),
        .rd_tag_o   (rd_tag_s),
        .rd_data_o  (rd_data_s),
        .wr_en_i    (wr_en_s),
        .wr_index_i (req_index_s),
        .wr_valid_i (wr_valid_s),
        .wr_dirty_i (wr_dirty_s),
        .wr_tag_i   (wr_tag_s),
        .wr_data_i  (wr_data_s)
    );

    assign hit_s      = (state_r == IDLE) && rd_valid_s && (rd_tag_s == req_tag_s);
    assign p1_stall_o = req_s && !hit_s;
    assign p1_data_o  = (req_s && hit_s) ? line_get_word(rd_data_s, req_word_s) : 32'h0000_0000;

    assign mem_enable_o = mem_enable_r;
    assign mem_write_o  = mem_write_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_data_o   = mem_data_r;

    // Array write port: refill install takes priority over a store hit.
    always_comb begin
        wr_en_s    = 1'b0;
        wr_valid_s = rd_valid_s;
        wr_dirty_s = rd_dirty_s;
        wr_tag_s   = rd_tag_s;
        wr_data_s  = rd_data_s;
        if (state_r == READMISSOK) begin
            wr_en_s    = 1'b1;
            wr_valid_s = 1'b1;
            wr_dirty_s = 1'b0;
            wr_tag_s   = req_tag_s;
            wr_data_s  = refill_r;
        end else if (req_s && hit_s && p1_MemWrite_i) begin
            wr_en_s    = 1'b1;
            wr_valid_s = 1'b1;
            wr_dirty_s = 1'b1;
            wr_data_s  = line_put_word(rd_data_s, req_word_s, p1_data_i);
        end else begin
            wr_en_s    = 1'b0;
        end
    end

    // Next-state decode for the miss handling FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s && !hit_s) state_nxt_s = MISS;
                else                 state_nxt_s = IDLE;
            end
            MISS: begin
                if (rd_valid_s && rd_dirty_s) state_nxt_s = WRITEBACK;
                else                          state_nxt_s = READMISS;
            end
            WRITEBACK: begin
                if (mem_ack_i) state_nxt_s = READMISS;
                else           state_nxt_s = WRITEBACK;
            end
            READMISS: begin
                if (mem_ack_i) state_nxt_s = READMISSOK;
                else           state_nxt_s = READMISS;
            end
            READMISSOK: state_nxt_s = IDLE;
            default:    state_nxt_s = IDLE;
        endcase
    end

    // State register with memory-side outputs registered from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            mem_enable_r <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            mem_data_r   <= {LINE_BITS{1'b0}};
            refill_r     <= {LINE_BITS{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            mem_enable_r <= (state_nxt_s == WRITEBACK) || (state_nxt_s == READMISS);
            mem_write_r  <= (state_nxt_s == WRITEBACK);
            if (state_r == MISS && state_nxt_s == WRITEBACK) begin
                mem_addr_r <= {rd_tag_s, req_index_s, 5'b00000};
                mem_data_r <= rd_data_s;
            end else if (state_r != READMISS && state_nxt_s == READMISS) begin
                mem_addr_r <= {req_tag_s, req_index_s, 5'b00000};
            end else begin
                mem_addr_r <= mem_addr_r;
            end
            if (state_r == READMISS && mem_ack_i) begin
                refill_r <= mem_data_i;
            end else begin
                refill_r <= refill_r;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a small line-wide memory model.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int checks = 0;
    int errors = 0;

    logic [255:0] mem_model [0:63];
    int           tx_n;
    logic [31:0]  tx_addr [0:7];
    logic         tx_we   [0:7];
    logic [255:0] tx_data [0:7];

    int           cyc;
    logic [31:0]  rdata;
    logic         fstall;

    dcache_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pipeline access: holds the request while stalled, acts as memory
    // (ack on the 4th cycle of each transfer), returns stall count and hit data.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output int ncyc,
                          output logic [31:0] data, output logic first_stall);
        int lat;
        @(negedge clk_i);
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        p1_addr_i     = addr;
        p1_data_i     = wdata;
        #1;
        first_stall = p1_stall_o;
        ncyc = 0;
        lat  = 0;
        tx_n = 0;
        while (p1_stall_o === 1'b1 && ncyc < 100) begin
            ncyc++;
            if (mem_enable_o === 1'b1) begin
                lat++;
                if (lat == 1 && tx_n < 8) begin
                    tx_addr[tx_n] = mem_addr_o;
                    tx_we[tx_n]   = mem_write_o;
                    tx_data[tx_n] = mem_data_o;
                    tx_n++;
                end
                if (lat == 4) begin
                    mem_ack_i = 1'b1;
                    lat = 0;
                    if (mem_write_o === 1'b1) mem_model[mem_addr_o[10:5]] = mem_data_o;
                    else                      mem_data_i = mem_model[mem_addr_o[10:5]];
                end
            end
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            #1;
        end
        chk("access_no_hang", (ncyc < 100), 1'b1);
        data = p1_data_o;
        @(negedge clk_i);
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 8; k++) begin
                mem_model[i][k*32 +: 32] = 32'h1000_0000 | (32'(i) << 8) | 32'(k);
            end
        end
        mem_model[2][31:0] = 32'h1111_1111;

        rst_i = 1'b1;
        p1_addr_i = 32'h0;
        p1_data_i = 32'h0;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
        mem_data_i = 256'h0;
        mem_ack_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("reset_stall", p1_stall_o, 1'b0);
        chk("reset_enable", mem_enable_o, 1'b0);
        chk("reset_write", mem_write_o, 1'b0);
        chk("reset_data_noreq", p1_data_o, 32'h0);

        // Cold read miss.
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, cyc, rdata, fstall);
        chk("cold_stall_first", fstall, 1'b1);
        chk("cold_stall_cycles", cyc, 7);
        chk("cold_data", rdata, 32'h1111_1111);
        chk("cold_tx_count", tx_n, 1);
        chk("cold_tx_we", tx_we[0], 1'b0);
        chk("cold_tx_addr", tx_addr[0], 32'h0000_0040);

        // Store hit then load hit.
        access(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, cyc, rdata, fstall);
        chk("store_hit_stall", fstall, 1'b0);
        chk("store_hit_cycles", cyc, 0);
        access(1'b1, 1'b0, 32'h0000_0044, 32'h0, cyc, rdata, fstall);
        chk("load_hit_cycles", cyc, 0);
        chk("load_hit_data", rdata, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, cyc, rdata, fstall);
        chk("load_hit_word0", rdata, 32'h1111_1111);

        // Conflict miss on a dirty line: writeback then refill.
        access(1'b1, 1'b0, 32'h0000_0444, 32'h0, cyc, rdata, fstall);
        chk("evict_cycles", cyc, 11);
        chk("evict_tx_count", tx_n, 2);
        chk("evict_wb_we", tx_we[0], 1'b1);
        chk("evict_wb_addr", tx_addr[0], 32'h0000_0040);
        chk("evict_wb_word1", tx_data[0][63:32], 32'hDEAD_BEEF);
        chk("evict_wb_word0", tx_data[0][31:0], 32'h1111_1111);
        chk("evict_rd_we", tx_we[1], 1'b0);
        chk("evict_rd_addr", tx_addr[1], 32'h0000_0440);
        chk("evict_data", rdata, 32'h1000_2201);

        // Both strobes high: treated as a write (victim clean, no writeback).
        access(1'b1, 1'b1, 32'h0000_0048, 32'h0000_0005, cyc, rdata, fstall);
        chk("rw_cycles", cyc, 7);
        chk("rw_tx_count", tx_n, 1);
        chk("rw_tx_we", tx_we[0], 1'b0);
        access(1'b1, 1'b0, 32'h0000_0048, 32'h0, cyc, rdata, fstall);
        chk("rw_load_cycles", cyc, 0);
        chk("rw_load_data", rdata, 32'h0000_0005);
        access(1'b1, 1'b0, 32'h0000_0044, 32'h0, cyc, rdata, fstall);
        chk("roundtrip_data", rdata, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'h0000_0448, 32'h0, cyc, rdata, fstall);
        chk("rw_dirty_wb_cycles", cyc, 11);
        chk("rw_dirty_wb_word2", tx_data[0][95:64], 32'h0000_0005);

        // Reset in the middle of a refill, with a late ack.
        @(negedge clk_i);
        p1_MemRead_i = 1'b1;
        p1_addr_i    = 32'h0000_0100;
        #1;
        for (int n = 0; n < 10; n++) begin
            if (mem_enable_o === 1'b1) break;
            @(negedge clk_i);
            #1;
        end
        chk("rst_mid_reached_readmiss", {mem_enable_o, mem_write_o}, 2'b10);
        rst_i = 1'b1;
        p1_MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_ack_i = 1'b1;
        mem_data_i = 256'h0;
        #1;
        chk("rst_mid_stall", p1_stall_o, 1'b0);
        chk("rst_mid_enable", mem_enable_o, 1'b0);
        chk("rst_mid_write", mem_write_o, 1'b0);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        chk("late_ack_enable", mem_enable_o, 1'b0);
        chk("late_ack_stall", p1_stall_o, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0100, 32'h0, cyc, rdata, fstall);
        chk("post_rst_miss_cycles", cyc, 7);
        chk("post_rst_data", rdata, 32'h1000_0800);
        access(1'b1, 1'b0, 32'h0000_0048, 32'h0, cyc, rdata, fstall);
        chk("post_rst_invalid_cycles", cyc, 7);
        chk("post_rst_mem_data", rdata, 32'h0000_0005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
